// File: rtl/legv8_pkg.sv
// Shared encodings for the LEGv8 multi-cycle controller: states, ALU ops,
// immediate formats, instruction classes and opcode match patterns.
package legv8_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD    = 3'd0,
    ALU_SUB    = 3'd1,
    ALU_AND    = 3'd2,
    ALU_ORR    = 3'd3,
    ALU_PASS_B = 3'd4
  } alu_op_t;

  typedef enum logic [1:0] {
    IMM_I  = 2'd0,
    IMM_D  = 2'd1,
    IMM_B  = 2'd2,
    IMM_CB = 2'd3
  } imm_sel_t;

  typedef enum logic [3:0] {
    CLS_ILL, CLS_R, CLS_ADDI, CLS_LDUR, CLS_STUR,
    CLS_CBZ, CLS_CBNZ, CLS_BCOND, CLS_B
  } op_class_t;

  localparam logic [10:0] OP_ADD   = 11'b10001011000;
  localparam logic [10:0] OP_SUB   = 11'b11001011000;
  localparam logic [10:0] OP_AND   = 11'b10001010000;
  localparam logic [10:0] OP_ORR   = 11'b10101010000;
  localparam logic [10:0] OP_ADDI  = 11'b10010001000;
  localparam logic [10:0] OP_LDUR  = 11'b11111000010;
  localparam logic [10:0] OP_STUR  = 11'b11111000000;
  localparam logic [10:0] OP_CBZ   = 11'b10110100000;
  localparam logic [10:0] OP_CBNZ  = 11'b10110101000;
  localparam logic [10:0] OP_BCOND = 11'b01010100000;
  localparam logic [10:0] OP_B     = 11'b00010100000;

  localparam logic [10:0] MASK_FULL = 11'b11111111111;
  localparam logic [10:0] MASK_ADDI = 11'b11111111110;
  localparam logic [10:0] MASK_CB   = 11'b11111111000;
  localparam logic [10:0] MASK_B    = 11'b11111100000;

  function automatic logic op_match(input logic [10:0] op,
                                    input logic [10:0] pat,
                                    input logic [10:0] mask);
    return (op & mask) == pat;
  endfunction

endpackage

// File: rtl/legv8_op_decode.sv
// Combinational opcode classifier; also yields the ALU op for R-type forms.
module legv8_op_decode
  import legv8_pkg::*;
(
  input  logic [10:0] opcode,
  output op_class_t   op_class,
  output alu_op_t     r_alu_op
);

  always_comb begin
    op_class = CLS_ILL;
    r_alu_op = ALU_ADD;
    if (op_match(opcode, OP_ADD, MASK_FULL)) begin
      op_class = CLS_R;
      r_alu_op = ALU_ADD;
    end else if (op_match(opcode, OP_SUB, MASK_FULL)) begin
      op_class = CLS_R;
      r_alu_op = ALU_SUB;
    end else if (op_match(opcode, OP_AND, MASK_FULL)) begin
      op_class = CLS_R;
      r_alu_op = ALU_AND;
    end else if (op_match(opcode, OP_ORR, MASK_FULL)) begin
      op_class = CLS_R;
      r_alu_op = ALU_ORR;
    end else if (op_match(opcode, OP_ADDI, MASK_ADDI)) begin
      op_class = CLS_ADDI;
    end else if (op_match(opcode, OP_LDUR, MASK_FULL)) begin
      op_class = CLS_LDUR;
    end else if (op_match(opcode, OP_STUR, MASK_FULL)) begin
      op_class = CLS_STUR;
    end else if (op_match(opcode, OP_CBZ, MASK_CB)) begin
      op_class = CLS_CBZ;
    end else if (op_match(opcode, OP_CBNZ, MASK_CB)) begin
      op_class = CLS_CBNZ;
    end else if (op_match(opcode, OP_BCOND, MASK_CB)) begin
      op_class = CLS_BCOND;
    end else if (op_match(opcode, OP_B, MASK_B)) begin
      op_class = CLS_B;
    end
  end

endmodule

// File: rtl/legv8_mc_ctrl.sv
// LEGv8 multi-cycle control sequencer with memory-ready timeout.
// Optional LEGV8_CTRL_PERF_EN adds cycle and retired-instruction counters.
//   state  | meaning
//   FETCH  | instruction read from memory, IR and PC+4 loaded on ready
//   DECODE | classify opcode, illegal -> HALT
//   EXEC   | ALU op / branch resolution
//   MEM    | data load or store via shared memory
//   WB     | register-file write
//   HALT   | fault, absorbing until reset
module legv8_mc_ctrl
  import legv8_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] opcode,
  input  logic        zero,
  input  logic        cond_true,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic [1:0]  imm_sel,
  output logic        alu_src,
  output logic [2:0]  alu_op,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        fault,
  output logic [2:0]  state
`ifdef LEGV8_CTRL_PERF_EN
  ,
  output logic [31:0] cyc_cnt,
  output logic [31:0] instr_cnt
`endif
);

  localparam int WAIT_W = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);

  state_t          cur_st, nxt_st;
  logic            active;
  logic            fault_set;
  logic [WAIT_W-1:0] wait_cnt;
  op_class_t       op_class;
  alu_op_t         r_alu_op;
  imm_sel_t        imm_cls;
  alu_op_t         alu_op_cls;
  logic            alu_src_cls;
  logic            taken;
  logic            mem_timeout;

  legv8_op_decode u_dec (
    .opcode   (opcode),
    .op_class (op_class),
    .r_alu_op (r_alu_op)
  );

  always_comb begin
    imm_cls     = IMM_I;
    alu_op_cls  = ALU_ADD;
    alu_src_cls = 1'b0;
    taken       = 1'b0;
    case (op_class)
      CLS_R:              alu_op_cls = r_alu_op;
      CLS_ADDI:           alu_src_cls = 1'b1;
      CLS_LDUR, CLS_STUR: begin
        imm_cls     = IMM_D;
        alu_src_cls = 1'b1;
      end
      CLS_CBZ: begin
        imm_cls    = IMM_CB;
        alu_op_cls = ALU_PASS_B;
        taken      = zero;
      end
      CLS_CBNZ: begin
        imm_cls    = IMM_CB;
        alu_op_cls = ALU_PASS_B;
        taken      = !zero;
      end
      CLS_BCOND: begin
        imm_cls = IMM_CB;
        taken   = cond_true;
      end
      CLS_B: begin
        imm_cls = IMM_B;
        taken   = 1'b1;
      end
      default: ;
    endcase
  end

  assign mem_timeout = !mem_ready && (wait_cnt == WAIT_LAST);

  // Nothing is driven until the first edge after reset release, so mem_req
  // drops together with rst_n and rises one cycle after deassertion.
  always_comb begin
    nxt_st     = cur_st;
    fault_set  = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    imm_sel    = IMM_I;
    alu_src    = 1'b0;
    alu_op     = ALU_ADD;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    if (active) begin
      case (cur_st)
        ST_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            nxt_st   = ST_DECODE;
          end else if (mem_timeout) begin
            nxt_st    = ST_HALT;
            fault_set = 1'b1;
          end
        end
        ST_DECODE: begin
          imm_sel = imm_cls;
          if (op_class == CLS_ILL) begin
            nxt_st    = ST_HALT;
            fault_set = 1'b1;
          end else begin
            nxt_st = ST_EXEC;
          end
        end
        ST_EXEC: begin
          imm_sel = imm_cls;
          alu_src = alu_src_cls;
          alu_op  = alu_op_cls;
          case (op_class)
            CLS_R, CLS_ADDI:    nxt_st = ST_WB;
            CLS_LDUR, CLS_STUR: nxt_st = ST_MEM;
            CLS_CBZ, CLS_CBNZ, CLS_BCOND, CLS_B: begin
              pc_write = taken;
              pc_src   = taken;
              nxt_st   = ST_FETCH;
            end
            default: begin
              nxt_st    = ST_HALT;
              fault_set = 1'b1;
            end
          endcase
        end
        ST_MEM: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          mem_we  = (op_class == CLS_STUR);
          imm_sel = imm_cls;
          alu_src = alu_src_cls;
          alu_op  = alu_op_cls;
          if (mem_ready) begin
            nxt_st = (op_class == CLS_LDUR) ? ST_WB : ST_FETCH;
          end else if (mem_timeout) begin
            nxt_st    = ST_HALT;
            fault_set = 1'b1;
          end
        end
        ST_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = (op_class == CLS_LDUR);
          imm_sel    = imm_cls;
          alu_src    = alu_src_cls;
          alu_op     = alu_op_cls;
          nxt_st     = ST_FETCH;
        end
        ST_HALT: ;
        default: begin
          nxt_st    = ST_HALT;
          fault_set = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_st   <= ST_FETCH;
      active   <= 1'b0;
      fault    <= 1'b0;
      wait_cnt <= '0;
    end else begin
      active <= 1'b1;
      cur_st <= nxt_st;
      fault  <= fault | fault_set;
      if (nxt_st != cur_st)
        wait_cnt <= '0;
      else if (mem_req && !mem_ready)
        wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  assign state = cur_st;

`ifdef LEGV8_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt   <= '0;
      instr_cnt <= '0;
    end else begin
      if (active && cur_st != ST_HALT)
        cyc_cnt <= cyc_cnt + 32'd1;
      if ((cur_st == ST_EXEC || cur_st == ST_MEM || cur_st == ST_WB) &&
          nxt_st == ST_FETCH)
        instr_cnt <= instr_cnt + 32'd1;
    end
  end
`endif

endmodule
